// File: rtl/filling_sequencer_if.sv
// Bottle-filling line bus: run request and sensor inputs from the line,
// actuator, alarm and count outputs back to the drivers.
interface filling_sequencer_if #(
  parameter int COUNT_W = 8
);
  logic               Start;
  logic               SensorG;
  logic               NivelCheio;
  logic               Esteira;
  logic               Valvula;
  logic               Vedacao;
  logic               Alarme;
  logic               Lote;
  logic [COUNT_W-1:0] Contagem;

  // Line side: drives the run request and sensors, observes the actuators
  modport master (
    output Start, SensorG, NivelCheio,
    input  Esteira, Valvula, Vedacao, Alarme, Lote, Contagem
  );

  // Sequencer side
  modport slave (
    input  Start, SensorG, NivelCheio,
    output Esteira, Valvula, Vedacao, Alarme, Lote, Contagem
  );
endinterface

// File: rtl/filling_sequencer.sv
// Per-bottle sequencer: move to fill position, fill to level, seal, release.
// Moore machine; every output decodes registered state, so no input reaches
// an output combinationally. Counts completed bottles and flags stuck stages.
module filling_sequencer #(
  parameter int MOVE_TIMEOUT = 100,
  parameter int FILL_TIMEOUT = 50,
  parameter int SEAL_CYCLES  = 4,
  parameter int COUNT_W      = 8
) (
  input logic                CLK,
  input logic                reset,
  filling_sequencer_if.slave bus
);

  localparam int TMAX_MF = (MOVE_TIMEOUT > FILL_TIMEOUT) ? MOVE_TIMEOUT : FILL_TIMEOUT;
  localparam int TMAX    = (TMAX_MF > SEAL_CYCLES) ? TMAX_MF : SEAL_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TIMEOUT - 1);
  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] SEAL_LAST = TW'(SEAL_CYCLES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] MOVE    = 3'd1;
  localparam logic [2:0] FILL    = 3'd2;
  localparam logic [2:0] SEAL    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] FAULT   = 3'd5;

  logic [2:0]         state, state_nxt;
  logic [TW-1:0]      timer;
  logic [COUNT_W-1:0] cnt;
  logic               lote;
  logic               seal_done;

  // Next-state selection; branch order encodes the priority between
  // simultaneous conditions (stop beats bottle arrival, full beats fault)
  always_comb begin
    state_nxt = state;
    seal_done = 1'b0;
    case (state)
      IDLE:    if (bus.Start) state_nxt = MOVE;
      MOVE: begin
        if (!bus.Start)              state_nxt = IDLE;
        else if (bus.SensorG)        state_nxt = FILL;
        else if (timer == MOVE_LAST) state_nxt = FAULT;
      end
      // Start is deliberately ignored here: a partial fill is never abandoned
      FILL: begin
        if (bus.NivelCheio)          state_nxt = SEAL;
        else if (!bus.SensorG)       state_nxt = FAULT;
        else if (timer == FILL_LAST) state_nxt = FAULT;
      end
      SEAL: begin
        if (timer == SEAL_LAST) begin
          state_nxt = RELEASE;
          seal_done = 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.SensorG)            state_nxt = bus.Start ? MOVE : IDLE;
        else if (timer == MOVE_LAST) state_nxt = FAULT;
      end
      FAULT:   if (!bus.Start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-state timer; timer restarts on every transition
  // and saturates in the open-ended states (IDLE, FAULT)
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) timer <= '0;
      else if (timer != '1)   timer <= timer + 1'b1;
    end
  end

  // Bottle counter and batch pulse; the pulse is high only for the cycle
  // after the counter wraps. Only reset clears the count.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      lote <= 1'b0;
    end else begin
      lote <= seal_done && (cnt == '1);
      if (seal_done) cnt <= cnt + 1'b1;
    end
  end

  assign bus.Esteira  = (state == MOVE) || (state == RELEASE);
  assign bus.Valvula  = (state == FILL);
  assign bus.Vedacao  = (state == SEAL);
  assign bus.Alarme   = (state == FAULT);
  assign bus.Lote     = lote;
  assign bus.Contagem = cnt;

endmodule

// File: tb/tb_filling_sequencer.sv
// Scenario bench for filling_sequencer (COUNT_W=2 so the count wrap is quick).
// Each cycle the expected output vector is queued as the stimulus is driven and
// popped for comparison once the edge has been taken.
module tb_filling_sequencer;

  localparam int CW = 2;

  typedef struct packed {
    logic [3:0]    act;   // {Esteira, Valvula, Vedacao, Alarme}
    logic [CW-1:0] cnt;
    logic          lote;
  } exp_t;

  localparam logic [3:0] A_ID = 4'b0000;
  localparam logic [3:0] A_MV = 4'b1000;
  localparam logic [3:0] A_FL = 4'b0100;
  localparam logic [3:0] A_SL = 4'b0010;
  localparam logic [3:0] A_FT = 4'b0001;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  filling_sequencer_if #(.COUNT_W(CW)) bus ();

  filling_sequencer #(.COUNT_W(CW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t sample();
    return {bus.Esteira, bus.Valvula, bus.Vedacao, bus.Alarme, bus.Contagem, bus.Lote};
  endfunction

  task automatic drive(input logic s, input logic g, input logic n);
    bus.Start      = s;
    bus.SensorG    = g;
    bus.NivelCheio = n;
  endtask

  task automatic test_reset();
    exp_t got, want;
    drive(0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 53; c++) begin
      if (c == 3) reset = 1'b1;
      exp_q.push_back(exp_t'{A_ID, 2'd0, 1'b0});
      tick();
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  // Full bottle, release back to MOVE, then a bottle lost during FILL
  task automatic test_basic_cycle();
    exp_t got, want;
    logic [3:0] a;
    for (int c = 0; c < 26; c++) begin
      drive(c <= 24, (c >= 5 && c <= 21) || c == 23, c == 15);
      a = (c <= 4) ? A_MV : (c <= 14) ? A_FL : (c <= 18) ? A_SL :
          (c <= 22) ? A_MV : (c == 23) ? A_FL : (c == 24) ? A_FT : A_ID;
      exp_q.push_back(exp_t'{a, (c >= 19) ? 2'd1 : 2'd0, 1'b0});
      tick();
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL basic c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  task automatic test_move_timeout();
    exp_t got, want;
    logic [3:0] a;
    for (int c = 0; c < 103; c++) begin
      drive(c <= 101, 0, 0);
      a = (c <= 99) ? A_MV : (c <= 101) ? A_FT : A_ID;
      exp_q.push_back(exp_t'{a, 2'd1, 1'b0});
      tick();
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL move_timeout c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  // Start dropped right after FILL entry: fill must run to its timeout
  task automatic test_fill_timeout();
    exp_t got, want;
    logic [3:0] a;
    for (int c = 0; c < 53; c++) begin
      drive(c <= 1, c >= 1, 0);
      a = (c == 0) ? A_MV : (c <= 50) ? A_FL : (c == 51) ? A_FT : A_ID;
      exp_q.push_back(exp_t'{a, 2'd1, 1'b0});
      tick();
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL fill_timeout c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  // Stop beats bottle arrival in MOVE; full beats bottle lost in FILL
  task automatic test_priority();
    exp_t got, want;
    logic [3:0] a;
    for (int c = 0; c < 10; c++) begin
      drive(c == 0 || (c >= 2 && c <= 8), c == 1 || c == 3, c == 4);
      a = (c == 0) ? A_MV : (c == 1) ? A_ID : (c == 2) ? A_MV : (c == 3) ? A_FL :
          (c <= 7) ? A_SL : (c == 8) ? A_MV : A_ID;
      exp_q.push_back(exp_t'{a, (c >= 8) ? 2'd2 : 2'd1, 1'b0});
      tick();
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL priority c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  // Reset pulled between edges while sealing: outputs drop at once
  task automatic test_reset_mid_seal();
    exp_t got, want;
    logic [3:0] a;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        drive(1, c >= 1, c == 2);
        a = (c == 0) ? A_MV : (c == 1) ? A_FL : A_SL;
        exp_q.push_back(exp_t'{a, 2'd2, 1'b0});
        tick();
      end else if (c == 4) begin
        #2 reset = 1'b0;
        exp_q.push_back(exp_t'{A_ID, 2'd0, 1'b0});
        #1;
      end else begin
        if (c == 7) begin
          drive(0, 0, 0);
          reset = 1'b1;
        end
        exp_q.push_back(exp_t'{A_ID, 2'd0, 1'b0});
        tick();
      end
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_seal c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  // Four quick bottles from count 0: 1,2,3,0 with the batch pulse on the wrap
  task automatic test_back_to_back_wrap();
    exp_t got, want;
    logic [3:0] a;
    logic [CW-1:0] ec;
    int b, k;
    for (int c = 0; c < 31; c++) begin
      b = (c >= 1) ? (c - 1) / 7 : 0;
      k = (c >= 1) ? (c - 1) % 7 : 6;
      if (c == 0) begin
        drive(1, 0, 0); a = A_MV; ec = 2'd0;
      end else if (c <= 28) begin
        drive(1, k != 6, k == 1);
        a  = (k == 0) ? A_FL : (k <= 4) ? A_SL : A_MV;
        ec = CW'((k >= 5) ? b + 1 : b);
      end else begin
        drive(0, 0, 0); a = A_ID; ec = 2'd0;
      end
      exp_q.push_back(exp_t'{a, ec, (c <= 28 && c >= 1 && b == 3 && k == 5)});
      tick();
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL wrap c=%0d got act=%b cnt=%0d lote=%b want act=%b cnt=%0d lote=%b",
                 c, got.act, got.cnt, got.lote, want.act, want.cnt, want.lote);
      end
    end
  endtask

  initial begin
    drive(0, 0, 0);
    #1;
    test_reset();
    test_basic_cycle();
    test_move_timeout();
    test_fill_timeout();
    test_priority();
    test_reset_mid_seal();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
